// File: rtl/param_arbiter.sv
// Clocked N-requester arbiter with fixed-priority or round-robin selection.
// Grants are registered and held until released, with an optional hold timeout.
module param_arbiter #(
  parameter int N_REQ    = 4,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 8,
  localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int HW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_id,
  output logic             timeout
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [HW-1:0]    hold;

  logic             win_found;
  logic [IW-1:0]    win_id;
  logic [N_REQ-1:0] win_onehot;
  logic [IW-1:0]    ptr_next;
  logic             other_pending;

  // Two passes give the wrap-around scan: indices at or above the pointer
  // first, then the rest. In fixed mode the first pass covers every index.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    win_found  = 1'b0;
    win_id     = '0;
    win_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req[i] && (RR_MODE == 0 || i >= int'(ptr))) begin
        win_found = 1'b1;
        win_id    = IW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req[i]) begin
        win_found = 1'b1;
        win_id    = IW'(i);
      end
    end
    if (win_found) win_onehot[win_id] = 1'b1;
  end

  assign ptr_next      = (win_id == IW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
  assign other_pending = |(req & ~grant);

  // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      hold        <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant       <= win_onehot;
            grant_id    <= win_id;
            grant_valid <= 1'b1;
            hold        <= '0;
            state       <= S_GRANT;
            if (RR_MODE != 0) ptr <= ptr_next;
          end
        end
        S_GRANT: begin
          if (!req[grant_id]) begin
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            state       <= S_IDLE;
          end else if (MAX_HOLD > 0 && hold == HW'(MAX_HOLD - 1) && other_pending) begin
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b1;
            state       <= S_IDLE;
          end else if (MAX_HOLD > 0 && hold != HW'(MAX_HOLD)) begin
            hold <= hold + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_arbiter.sv
// Directed bench for param_arbiter: a 4-way round-robin instance with a short
// hold limit and a 3-way fixed-priority instance replaying the legacy cases.
module tb_param_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [3:0] req_rr = '0;
  logic [3:0] grant_rr;
  logic       valid_rr;
  logic [1:0] id_rr;
  logic       to_rr;

  logic [2:0] req_fx = '0;
  logic [2:0] grant_fx;
  logic       valid_fx;
  logic [1:0] id_fx;
  logic       to_fx;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_arbiter #(.N_REQ(4), .RR_MODE(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst(rst), .req(req_rr), .grant(grant_rr),
    .grant_valid(valid_rr), .grant_id(id_rr), .timeout(to_rr)
  );

  param_arbiter #(.N_REQ(3), .RR_MODE(0)) u_fx (
    .clk(clk), .rst(rst), .req(req_fx), .grant(grant_fx),
    .grant_valid(valid_fx), .grant_id(id_fx), .timeout(to_fx)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rr(input string tag, input logic [3:0] g, input logic [1:0] id,
                          input logic to);
    check({tag, ".grant"}, 32'(grant_rr), 32'(g));
    check({tag, ".valid"}, 32'(valid_rr), 32'(|g));
    check({tag, ".id"},    32'(id_rr),    32'(id));
    check({tag, ".tout"},  32'(to_rr),    32'(to));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [1:0] rr_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [2:0] fx_req   [7] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110, 3'b111};
  logic [1:0] fx_id    [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0};

  initial begin
    #1;
    // Reset state and first round-robin grant
    rst = 1'b1;
    tick();
    check_rr("rst", 4'b0000, 2'd0, 1'b0);
    check("rst.fx_grant", 32'(grant_fx), 32'd0);
    rst = 1'b0;
    req_rr = 4'b0101;
    tick();
    check_rr("t1.first", 4'b0001, 2'd0, 1'b0);
    req_rr = 4'b0100;
    tick();
    check_rr("t1.bubble", 4'b0000, 2'd0, 1'b0);
    tick();
    check_rr("t1.second", 4'b0100, 2'd2, 1'b0);
    req_rr = 4'b0000;
    tick();
    check_rr("t1.release", 4'b0000, 2'd0, 1'b0);

    // Round-robin fairness with pointer wrap 3 -> 0
    do_reset();
    req_rr = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_rr($sformatf("t2.g%0d.c1", k), 4'b0001 << rr_order[k], rr_order[k], 1'b0);
      tick();
      check_rr($sformatf("t2.g%0d.c2", k), 4'b0001 << rr_order[k], rr_order[k], 1'b0);
      req_rr = 4'b1111 & ~(4'b0001 << rr_order[k]);
      tick();
      check_rr($sformatf("t2.g%0d.gap", k), 4'b0000, 2'd0, 1'b0);
      req_rr = 4'b1111;
    end
    req_rr = 4'b0000;
    tick();

    // Timeout with MAX_HOLD=4
    do_reset();
    req_rr = 4'b0010;
    tick();
    check_rr("t4.c1", 4'b0010, 2'd1, 1'b0);
    req_rr = 4'b1010;
    for (int k = 2; k <= 4; k++) begin
      tick();
      check_rr($sformatf("t4.c%0d", k), 4'b0010, 2'd1, 1'b0);
    end
    tick();
    check_rr("t4.revoke", 4'b0000, 2'd0, 1'b1);
    tick();
    check_rr("t4.next", 4'b1000, 2'd3, 1'b0);
    req_rr = 4'b0000;
    tick();
    check_rr("t4.release", 4'b0000, 2'd0, 1'b0);

    // No contention: grant persists past MAX_HOLD, no timeout
    do_reset();
    req_rr = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_rr($sformatf("t5.c%0d", k), 4'b0100, 2'd2, 1'b0);
    end

    // Reset mid-grant overrides it and clears the pointer
    req_rr = 4'b1111;
    rst = 1'b1;
    tick();
    check_rr("t6.rst", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    check_rr("t6.after", 4'b0001, 2'd0, 1'b0);
    req_rr = 4'b0000;
    tick();

    // Fixed priority, legacy 3-way cases
    for (int k = 0; k < 7; k++) begin
      req_fx = fx_req[k];
      tick();
      check($sformatf("t3.%b.grant", fx_req[k]), 32'(grant_fx), 32'(3'b001 << fx_id[k]));
      check($sformatf("t3.%b.id", fx_req[k]), 32'(id_fx), 32'(fx_id[k]));
      check($sformatf("t3.%b.valid", fx_req[k]), 32'(valid_fx), 32'd1);
      req_fx = 3'b000;
      tick();
      check($sformatf("t3.%b.idle", fx_req[k]), 32'(grant_fx), 32'd0);
    end
    tick();
    check("t3.zero.grant", 32'(grant_fx), 32'd0);
    check("t3.zero.valid", 32'(valid_fx), 32'd0);
    check("t3.zero.tout", 32'(to_fx), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
